reg_bank_write_arbiter: RTL and testbench

Shares one write port of an enable-gated register bank (Depth entries × Width bits, async-reset D flip-flops) between NumReq requesters using round-robin arbitration. Also sequences a bank-wide clear sweep and provides one registered read port. Sits between multiple producer engines (config loaders, weight/bias writers) and the shared parameter register bank in the datapath.

---
 rtl/reg_bank_write_arbiter.sv | 205 ++++++++++++++++++++
 tb/tb_reg_bank_write_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_write_arbiter.sv
// Round-robin arbiter sharing one write port of a register bank,
// with a bank-wide clear sweep and a registered read port.
//
// Ports:
//   clk_i, rst_i         clock, async active-high reset
//   req_valid_i          per-requester write request
//   req_addr_i           packed addresses, k at [k*AddrW +: AddrW]
//   req_data_i           packed data, k at [k*Width +: Width]
//   req_ready_o          one-hot-or-zero grant (accept on valid&ready)
//   clear_i              start a clear sweep of every entry
//   clear_busy_o         high while the sweep runs
//   rd_addr_i            read address
//   rd_data_o            registered read data (0 when out of range)
module reg_bank_write_arbiter #(
  parameter int NumReq = 4,
  parameter int Width  = 8,
  parameter int Depth  = 16,
  parameter int AddrW  = $clog2(Depth)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NumReq-1:0]       req_valid_i,
  input  logic [NumReq*AddrW-1:0] req_addr_i,
  input  logic [NumReq*Width-1:0] req_data_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic                    clear_i,
  output logic                    clear_busy_o,
  input  logic [AddrW-1:0]        rd_addr_i,
  output logic [Width-1:0]        rd_data_o
);

  localparam int PtrW = $clog2(NumReq);
  localparam int CndW = PtrW + 1;

  localparam logic [PtrW-1:0] LastReq =
    PtrW'(NumReq - 1);
  localparam logic [AddrW-1:0] LastEnt =
    AddrW'(Depth - 1);
  localparam logic [AddrW:0] DepthW =
    (AddrW + 1)'(Depth);
  localparam logic [CndW-1:0] NumReqW =
    CndW'(NumReq);

  typedef enum logic {
    SERVE,
    CLEAR
  } state_t;

  state_t state_q, state_d;

  logic [PtrW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [AddrW-1:0] clr_cnt_q, clr_cnt_d;
  logic [Width-1:0] bank_q [Depth];

  logic             arb_en;
  logic             clr_act;
  logic             gnt_vld;
  logic [PtrW-1:0]  gnt_idx;
  logic [CndW-1:0]  cand;
  logic [AddrW-1:0] wr_addr;
  logic [Width-1:0] wr_data;
  logic             wr_hit;
  logic             rd_ok;
  logic [Depth-1:0] ent_we;
  logic [Width-1:0] ent_wd;

  // Reset also masks grants so nothing is
  // offered while the bank is being zeroed.
  assign arb_en  = (state_q == SERVE)
                 && !clear_i && !rst_i;
  assign clr_act = (state_q == CLEAR);

  assign clear_busy_o = clr_act;

  // Search from rr_ptr upward, wrapping
  // modulo NumReq; first valid one wins.
  always_comb begin : arb
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand    = '0;
    for (int i = 0; i < NumReq; i++) begin
      cand = {1'b0, rr_ptr_q} + CndW'(i);
      if (cand >= NumReqW) begin
        cand = cand - NumReqW;
      end
      if (!gnt_vld &&
          req_valid_i[cand[PtrW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand[PtrW-1:0];
      end
    end
    gnt_vld = gnt_vld & arb_en;
  end

  always_comb begin : ready
    req_ready_o = '0;
    if (gnt_vld) begin
      req_ready_o[gnt_idx] = 1'b1;
    end
  end

  always_comb begin : ptr
    rr_ptr_d = rr_ptr_q;
    if (gnt_vld) begin
      rr_ptr_d = (gnt_idx == LastReq)
               ? '0
               : gnt_idx + 1'b1;
    end
  end

  assign wr_addr =
    req_addr_i[32'(gnt_idx)*AddrW +: AddrW];
  assign wr_data =
    req_data_i[32'(gnt_idx)*Width +: Width];

  // Out-of-range writes still take the grant
  // but never reach the bank.
  assign wr_hit = gnt_vld
                && ({1'b0, wr_addr} < DepthW);

  assign rd_ok = {1'b0, rd_addr_i} < DepthW;

  always_comb begin : fsm
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    unique case (state_q)
      SERVE: begin
        if (clear_i) begin
          state_d   = CLEAR;
          clr_cnt_d = '0;
        end
      end
      CLEAR: begin
        if (clr_cnt_q == LastEnt) begin
          state_d   = SERVE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d   = SERVE;
        clr_cnt_d = '0;
      end
    endcase
  end

  // Sweep and arbitrated write are mutually
  // exclusive: grants only exist in SERVE.
  always_comb begin : bank_we
    ent_we = '0;
    ent_wd = '0;
    unique case (1'b1)
      clr_act: begin
        for (int e = 0; e < Depth; e++) begin
          ent_we[e] =
            (clr_cnt_q == AddrW'(e));
        end
      end
      wr_hit: begin
        for (int e = 0; e < Depth; e++) begin
          ent_we[e] =
            (wr_addr == AddrW'(e));
        end
        ent_wd = wr_data;
      end
      default: begin
        ent_we = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= SERVE;
      rr_ptr_q  <= '0;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      rr_ptr_q  <= rr_ptr_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Read samples the pre-write contents, so a
  // same-edge write shows up one edge later.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int e = 0; e < Depth; e++) begin
        bank_q[e] <= '0;
      end
      rd_data_o <= '0;
    end else begin
      for (int e = 0; e < Depth; e++) begin
        if (ent_we[e]) begin
          bank_q[e] <= ent_wd;
        end
      end
      rd_data_o <= rd_ok
                 ? bank_q[rd_addr_i]
                 : '0;
    end
  end

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Scoreboard bench for reg_bank_write_arbiter:
// grant and read expectations are queued, monitors pop them.
`timescale 1ns/1ps
module tb_reg_bank_write_arbiter;

  localparam int NumReq = 4;
  localparam int Width  = 8;
  localparam int Depth  = 16;
  localparam int AddrW  = 4;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b0;
  logic [NumReq-1:0]       req_valid_i = '0;
  logic [NumReq*AddrW-1:0] req_addr_i = '0;
  logic [NumReq*Width-1:0] req_data_i = '0;
  logic [NumReq-1:0]       req_ready_o;
  logic                    clear_i = 1'b0;
  logic                    clear_busy_o;
  logic [AddrW-1:0]        rd_addr_i = '0;
  logic [Width-1:0]        rd_data_o;

  int checks = 0;
  int errors = 0;

  int         exp_gnt[$];
  logic [7:0] exp_rd[$];
  logic       rd_chk = 1'b0;

  int         mon_e;
  logic [3:0] mon_oh;
  logic [7:0] mon_rd;

  reg_bank_write_arbiter #(
    .NumReq(NumReq),
    .Width (Width),
    .Depth (Depth)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .clear_i     (clear_i),
    .clear_busy_o(clear_busy_o),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o)
  );

  initial forever #5 clk_i = ~clk_i;

  initial begin
    #100000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  // Grant monitor: every offered grant must match
  // the next queued requester index.
  always @(negedge clk_i) begin
    if (!rst_i && req_ready_o != '0) begin
      checks++;
      if (exp_gnt.size() == 0) begin
        errors++;
        $display("FAIL gnt_unexpected act=%b exp=none",
                 req_ready_o);
      end else begin
        mon_e  = exp_gnt.pop_front();
        mon_oh = 4'(1 << mon_e);
        if (req_ready_o !== mon_oh ||
            (req_ready_o & ~req_valid_i) != '0) begin
          errors++;
          $display("FAIL gnt act=%b exp=%b",
                   req_ready_o, mon_oh);
        end
      end
    end
  end

  // Read monitor: fires when the stimulus marks
  // a cycle whose rd_data_o is defined.
  always @(negedge clk_i) begin
    if (rd_chk) begin
      checks++;
      if (exp_rd.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected act=%h exp=none",
                 rd_data_o);
      end else begin
        mon_rd = exp_rd.pop_front();
        if (rd_data_o !== mon_rd) begin
          errors++;
          $display("FAIL rd act=%h exp=%h",
                   rd_data_o, mon_rd);
        end
      end
    end
  end

  task automatic chk(string nm,
                     logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h",
               nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_req(int k,
                         logic [3:0] a,
                         logic [7:0] d);
    req_addr_i[k*AddrW +: AddrW] = a;
    req_data_i[k*Width +: Width] = d;
  endtask

  task automatic rd_probe(logic [7:0] e);
    exp_rd.push_back(e);
    rd_chk = 1'b1;
    @(negedge clk_i);
    #1 rd_chk = 1'b0;
    @(posedge clk_i);
    #1;
  endtask

  task automatic rd_expect(logic [3:0] a,
                           logic [7:0] e);
    rd_addr_i = a;
    tick();
    rd_probe(e);
  endtask

  task automatic wr_one(int k,
                        logic [3:0] a,
                        logic [7:0] d);
    set_req(k, a, d);
    exp_gnt.push_back(k);
    req_valid_i = 4'(1 << k);
    tick();
    req_valid_i = '0;
  endtask

  initial begin
    // Reset with inputs toggling
    #2 rst_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1;
      req_valid_i = 4'(i * 5 + 3);
      clear_i     = i[0];
      rd_addr_i   = 4'(i * 3 + 3);
      set_req(i, 4'(i), 8'(i * 17 + 1));
      @(negedge clk_i);
      chk("rst_ready", 32'(req_ready_o), 0);
      chk("rst_busy", 32'(clear_busy_o), 0);
      chk("rst_rd", 32'(rd_data_o), 0);
    end
    @(posedge clk_i);
    #1;
    req_valid_i = '0;
    clear_i     = 1'b0;
    rd_addr_i   = '0;
    req_addr_i  = '0;
    req_data_i  = '0;
    rst_i       = 1'b0;
    @(negedge clk_i);
    chk("idle_ready", 32'(req_ready_o), 0);
    chk("idle_busy", 32'(clear_busy_o), 0);
    chk("idle_rd", 32'(rd_data_o), 0);
    tick();

    // Single requester 2 write
    wr_one(2, 4'd3, 8'hA5);
    rd_expect(4'd3, 8'hA5);

    // Requester 3 brings rr_ptr back to 0
    wr_one(3, 4'd7, 8'h77);

    // All four valid: 0,1,2,3,0
    set_req(0, 4'd8, 8'h80);
    set_req(1, 4'd9, 8'h91);
    set_req(2, 4'd10, 8'hA2);
    set_req(3, 4'd11, 8'hB3);
    exp_gnt.push_back(0);
    exp_gnt.push_back(1);
    exp_gnt.push_back(2);
    exp_gnt.push_back(3);
    exp_gnt.push_back(0);
    req_valid_i = 4'b1111;
    repeat (5) tick();

    // Only 1 and 3: 1,3,1,3
    exp_gnt.push_back(1);
    exp_gnt.push_back(3);
    exp_gnt.push_back(1);
    exp_gnt.push_back(3);
    req_valid_i = 4'b1010;
    repeat (4) tick();
    req_valid_i = '0;

    rd_expect(4'd9, 8'h91);
    rd_expect(4'd11, 8'hB3);
    rd_expect(4'd7, 8'h77);

    // Fill every entry through requester 0
    for (int i = 0; i < Depth; i++) begin
      set_req(0, 4'(i), 8'(8'h40 + i));
      exp_gnt.push_back(0);
      req_valid_i = 4'b0001;
      tick();
    end
    req_valid_i = '0;
    rd_expect(4'd15, 8'h4F);

    // Clear pulse with requester 0 pending
    set_req(0, 4'd2, 8'hEE);
    req_valid_i = 4'b0001;
    clear_i     = 1'b1;
    @(negedge clk_i);
    chk("clr_req_ready", 32'(req_ready_o), 0);
    chk("clr_req_busy", 32'(clear_busy_o), 0);
    exp_gnt.push_back(0);
    @(posedge clk_i);
    #1 clear_i = 1'b0;
    for (int i = 0; i < Depth; i++) begin
      @(negedge clk_i);
      chk("clr_busy", 32'(clear_busy_o), 1);
      chk("clr_ready", 32'(req_ready_o), 0);
      @(posedge clk_i);
      #1;
    end
    @(negedge clk_i);
    chk("clr_done_busy", 32'(clear_busy_o), 0);
    @(posedge clk_i);
    #1 req_valid_i = '0;
    for (int i = 0; i < Depth; i++) begin
      rd_expect(4'(i), (i == 2) ? 8'hEE : 8'h00);
    end

    // Read-before-write on the same address
    wr_one(1, 4'd5, 8'h11);
    set_req(1, 4'd5, 8'h3C);
    exp_gnt.push_back(1);
    req_valid_i = 4'b0010;
    rd_addr_i   = 4'd5;
    tick();
    req_valid_i = '0;
    rd_probe(8'h11);
    rd_probe(8'h3C);

    // Reset in the middle of a sweep
    wr_one(2, 4'd12, 8'h99);
    rd_expect(4'd12, 8'h99);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    repeat (7) tick();
    rst_i = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(clear_busy_o), 0);
    chk("mid_rst_rd", 32'(rd_data_o), 0);
    repeat (2) tick();
    rst_i = 1'b0;
    rd_expect(4'd12, 8'h00);
    rd_expect(4'd5, 8'h00);
    exp_gnt.push_back(0);
    req_valid_i = 4'b1111;
    tick();
    req_valid_i = '0;
    tick();

    chk("gnt_q_empty", 32'(exp_gnt.size()), 0);
    chk("rd_q_empty", 32'(exp_rd.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
